// File: rtl/sys_drain_collector_pkg.sv
// Shared defaults, FSM state encoding and thermometer helper for the
// systolic-array result drain collector.
package sys_drain_collector_pkg;

   localparam int ROW_A_DEF  = 4;
   localparam int COL_B_DEF  = 4;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } drain_state_e;

   // Thermometer code with the low k bits set; callers truncate to the
   // Johnson counter width.
   function automatic logic [31:0] therm(input int k);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         m[i] = (i < k);
      end
      return m;
   endfunction

endpackage

// File: rtl/sys_drain_collector_drain_out_reg.sv
// Single-entry valid/ready holding register. A load in the same edge as an
// accepted transfer wins, so the stream keeps one row per cycle.
module drain_out_reg
   import sys_drain_collector_pkg::*;
#(
   parameter int W  = 128,
   parameter int IW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [W-1:0]  data_i,
   input  logic [IW-1:0] idx_i,
   input  logic          last_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [W-1:0]  data_o,
   output logic [IW-1:0] idx_o,
   output logic          last_o
);

   logic          valid_q, valid_d;
   logic [W-1:0]  data_q;
   logic [IW-1:0] idx_q;
   logic          last_q;

   // Valid next-state: load has priority over the downstream accept.
   always_comb begin
      valid_d = valid_q;
      if (load_i) begin
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Holding register; payload only moves on a load so it is stable under stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_i) begin
            data_q <= data_i;
            idx_q  <= idx_i;
            last_q <= last_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign idx_o   = idx_q;
   assign last_o  = last_q;

endmodule

// File: rtl/sys_drain_collector.sv
// Drain sequencer for the systolic array: clears the row-select Johnson
// counter, strobes deload once per row, checks the counter against the
// expected thermometer code and streams the captured rows out.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_CLR   | one-cycle Johnson counter clear
//   ST_DRAIN | deload rows whenever the output register can take one
//   ST_FLUSH | last row captured, waiting for it to be accepted
//   ST_DONE  | one-cycle done pulse
module sys_drain_collector
   import sys_drain_collector_pkg::*;
#(
   parameter  int ROW_A  = ROW_A_DEF,
   parameter  int COL_B  = COL_B_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int RW     = COL_B * DATA_W,
   localparam int KW     = $clog2(ROW_A + 1),
   localparam int IW     = $clog2(ROW_A)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   output logic             jc_reset_o,
   output logic             deload_o,
   input  logic [ROW_A-1:0] johnson_count_i,
   input  logic [RW-1:0]    row_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [RW-1:0]    out_data_o,
   output logic [IW-1:0]    out_row_idx_o,
   output logic             out_last_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             seq_err_o
);

   drain_state_e     state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic             seq_err_q, seq_err_d;
   logic             capture;
   logic             k_is_last;
   logic             seq_mismatch;
   logic [ROW_A-1:0] therm_k;
   logic [IW-1:0]    cap_idx;

   assign therm_k      = ROW_A'(therm(int'(k_q)));
   assign seq_mismatch = (johnson_count_i != therm_k);
   assign k_is_last    = (k_q == KW'(ROW_A - 1));
   // Bottom row leaves first, so capture k carries array row ROW_A-1-k.
   assign cap_idx      = IW'(ROW_A - 1 - int'(k_q));

   // Next-state, capture strobe and sequence check.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      seq_err_d  = seq_err_q;
      jc_reset_o = 1'b0;
      capture    = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_CLR;
               seq_err_d = 1'b0;
            end
         end
         ST_CLR: begin
            jc_reset_o = 1'b1;
            k_d        = '0;
            state_d    = ST_DRAIN;
         end
         ST_DRAIN: begin
            // Only advance when the holding register is free or emptying.
            capture = !out_valid_o || out_ready_i;
            if (capture) begin
               if (seq_mismatch) begin
                  seq_err_d = 1'b1;
               end
               k_d = (k_q == KW'(ROW_A)) ? k_q : k_q + KW'(1);
               if (k_is_last) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (out_valid_o && out_ready_i && out_last_o) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, capture count and sticky sequence error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         seq_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign deload_o  = capture;
   assign busy_o    = (state_q != ST_IDLE);
   assign seq_err_o = seq_err_q;

   drain_out_reg #(
      .W  (RW),
      .IW (IW)
   ) u_out_reg (
      .clk     (clk),
      .reset   (reset),
      .load_i  (capture),
      .data_i  (row_data_i),
      .idx_i   (cap_idx),
      .last_i  (k_is_last),
      .ready_i (out_ready_i),
      .valid_o (out_valid_o),
      .data_o  (out_data_o),
      .idx_o   (out_row_idx_o),
      .last_o  (out_last_o)
   );

endmodule
